// File: rtl/branch_resolve_if.sv
// Branch-resolve bundle: EX-stage branch request in, redirect/flush out.
// master = EX/hazard side (drives request), slave = branch_resolve.
interface branch_resolve_if;
  logic        stall;
  logic        br_valid;
  logic [31:0] cmp_s;
  logic [31:0] br_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        busy;
  logic        addr_err;
  logic [15:0] taken_cnt;
  logic [15:0] nottaken_cnt;

  modport master (
    output stall, br_valid, cmp_s, br_target,
    input  redirect_valid, redirect_pc,
    input  flush_if_id, flush_id_ex, busy,
    input  addr_err, taken_cnt, nottaken_cnt
  );

  modport slave (
    input  stall, br_valid, cmp_s, br_target,
    output redirect_valid, redirect_pc,
    output flush_if_id, flush_id_ex, busy,
    output addr_err, taken_cnt, nottaken_cnt
  );
endinterface

// File: rtl/branch_resolve.sv
// Resolves EX-stage conditional branches: redirect fetch, flush IF/ID and
// ID/EX for FLUSH_CYCLES cycles, flag misaligned targets, count outcomes.
// Ports: clk, reset (sync, active-high), bus (branch_resolve_if.slave).
module branch_resolve #(
  parameter int FLUSH_CYCLES = 2
) (
  input logic              clk,
  input logic              reset,
  branch_resolve_if.slave  bus
);

  localparam logic [3:0] FL_INIT = 4'(FLUSH_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t      state;
  logic [3:0]  flush_left;
  logic        accept;
  logic        taken;
  logic        aligned;

  assign accept  = (state == IDLE) && bus.br_valid && !bus.stall;
  assign taken   = bus.cmp_s[0];
  assign aligned = (bus.br_target[1:0] == 2'b00);

  // Flush/busy are registered alongside state so they always
  // mirror (state == FLUSH) without a combinational decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      flush_left         <= 4'd0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= 32'h0;
      bus.flush_if_id    <= 1'b0;
      bus.flush_id_ex    <= 1'b0;
      bus.busy           <= 1'b0;
      bus.addr_err       <= 1'b0;
      bus.taken_cnt      <= 16'h0;
      bus.nottaken_cnt   <= 16'h0;
    end else begin
      // Pulses: one cycle only, independent of stall.
      bus.redirect_valid <= 1'b0;
      bus.addr_err       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (!taken) begin
              if (bus.nottaken_cnt != 16'hFFFF)
                bus.nottaken_cnt <= bus.nottaken_cnt + 16'd1;
            end else if (aligned) begin
              bus.redirect_pc    <= bus.br_target;
              bus.redirect_valid <= 1'b1;
              state              <= FLUSH;
              flush_left         <= FL_INIT;
              bus.flush_if_id    <= 1'b1;
              bus.flush_id_ex    <= 1'b1;
              bus.busy           <= 1'b1;
              if (bus.taken_cnt != 16'hFFFF)
                bus.taken_cnt <= bus.taken_cnt + 16'd1;
            end else begin
              bus.addr_err <= 1'b1;
            end
          end
        end
        FLUSH: begin
          // br_valid here belongs to a squashed instruction.
          if (!bus.stall) begin
            if (flush_left == 4'd0) begin
              state           <= IDLE;
              bus.flush_if_id <= 1'b0;
              bus.flush_id_ex <= 1'b0;
              bus.busy        <= 1'b0;
            end else begin
              flush_left <= flush_left - 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve.
// Linear stimulus; immediate-assertion checks against hand-computed values.
module tb_branch_resolve;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   nf;
  int   nr;

  branch_resolve_if bif ();

  branch_resolve #(.FLUSH_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".rv"},   32'(bif.redirect_valid), 32'h0);
    chk({tag, ".pc"},   bif.redirect_pc,         32'h0);
    chk({tag, ".fi"},   32'(bif.flush_if_id),    32'h0);
    chk({tag, ".fe"},   32'(bif.flush_id_ex),    32'h0);
    chk({tag, ".busy"}, 32'(bif.busy),           32'h0);
    chk({tag, ".aerr"}, 32'(bif.addr_err),       32'h0);
    chk({tag, ".tc"},   32'(bif.taken_cnt),      32'h0);
    chk({tag, ".ntc"},  32'(bif.nottaken_cnt),   32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bif.stall     = 1'b0;
    bif.br_valid  = 1'b0;
    bif.cmp_s     = 32'h0;
    bif.br_target = 32'h0;
    tick();
    tick();
    chk_zero("reset");
    reset = 1'b0;

    // Taken, aligned
    bif.br_valid  = 1'b1;
    bif.cmp_s     = 32'h1;
    bif.br_target = 32'h0040_0020;
    tick();
    bif.br_valid = 1'b0;
    chk("tk.rv",   32'(bif.redirect_valid), 32'h1);
    chk("tk.pc",   bif.redirect_pc,         32'h0040_0020);
    chk("tk.fi",   32'(bif.flush_if_id),    32'h1);
    chk("tk.fe",   32'(bif.flush_id_ex),    32'h1);
    chk("tk.busy", 32'(bif.busy),           32'h1);
    chk("tk.tc",   32'(bif.taken_cnt),      32'h1);
    tick();
    chk("tk.rv2",  32'(bif.redirect_valid), 32'h0);
    chk("tk.fi2",  32'(bif.flush_if_id),    32'h1);
    chk("tk.busy2", 32'(bif.busy),          32'h1);
    tick();
    chk("tk.fi3",  32'(bif.flush_if_id),    32'h0);
    chk("tk.fe3",  32'(bif.flush_id_ex),    32'h0);
    chk("tk.busy3", 32'(bif.busy),          32'h0);
    chk("tk.pc3",  bif.redirect_pc,         32'h0040_0020);

    // Not taken; upper compare bits ignored
    bif.br_valid  = 1'b1;
    bif.cmp_s     = 32'hFFFF_FFFE;
    bif.br_target = 32'h0000_0100;
    tick();
    bif.br_valid = 1'b0;
    chk("nt.rv",  32'(bif.redirect_valid), 32'h0);
    chk("nt.fi",  32'(bif.flush_if_id),    32'h0);
    chk("nt.ntc", 32'(bif.nottaken_cnt),   32'h1);
    chk("nt.tc",  32'(bif.taken_cnt),      32'h1);

    // Taken with stall for the first 3 FLUSH cycles
    bif.br_valid  = 1'b1;
    bif.cmp_s     = 32'h1;
    bif.br_target = 32'h0040_0040;
    tick();
    bif.br_valid = 1'b0;
    nf = 0;
    nr = 0;
    for (int k = 0; k < 12; k++) begin
      bif.stall = (k < 3);
      if (bif.flush_if_id) nf++;
      if (bif.redirect_valid) nr++;
      tick();
    end
    bif.stall = 1'b0;
    chk("st.flush_cycles", 32'(nf), 32'd5);
    chk("st.redirects",    32'(nr), 32'd1);
    chk("st.tc", 32'(bif.taken_cnt), 32'h2);

    // Misaligned target
    bif.br_valid  = 1'b1;
    bif.cmp_s     = 32'h1;
    bif.br_target = 32'h0040_0022;
    tick();
    bif.br_valid = 1'b0;
    chk("ma.aerr", 32'(bif.addr_err),       32'h1);
    chk("ma.rv",   32'(bif.redirect_valid), 32'h0);
    chk("ma.busy", 32'(bif.busy),           32'h0);
    chk("ma.tc",   32'(bif.taken_cnt),      32'h2);
    chk("ma.pc",   bif.redirect_pc,         32'h0040_0040);
    tick();
    chk("ma.aerr2", 32'(bif.addr_err), 32'h0);

    // Stalled in IDLE: held, then accepted when unstalled
    bif.br_valid  = 1'b1;
    bif.cmp_s     = 32'h1;
    bif.br_target = 32'h0000_0080;
    bif.stall     = 1'b1;
    tick();
    chk("si.rv",   32'(bif.redirect_valid), 32'h0);
    chk("si.busy", 32'(bif.busy),           32'h0);
    bif.stall = 1'b0;
    tick();
    chk("si.rv2", 32'(bif.redirect_valid), 32'h1);
    chk("si.pc",  bif.redirect_pc,         32'h0000_0080);
    chk("si.tc",  32'(bif.taken_cnt),      32'h3);

    // Back-to-back: br_valid during FLUSH ignored, first IDLE accepted
    bif.br_target = 32'h0000_00C0;
    tick();
    chk("bb.rv1",   32'(bif.redirect_valid), 32'h0);
    chk("bb.busy1", 32'(bif.busy),           32'h1);
    chk("bb.tc1",   32'(bif.taken_cnt),      32'h3);
    tick();
    chk("bb.rv2",   32'(bif.redirect_valid), 32'h0);
    chk("bb.busy2", 32'(bif.busy),           32'h0);
    chk("bb.tc2",   32'(bif.taken_cnt),      32'h3);
    chk("bb.aerr2", 32'(bif.addr_err),       32'h0);
    tick();
    bif.br_valid = 1'b0;
    chk("bb.rv3", 32'(bif.redirect_valid), 32'h1);
    chk("bb.pc3", bif.redirect_pc,         32'h0000_00C0);
    chk("bb.tc3", 32'(bif.taken_cnt),      32'h4);
    tick();
    tick();
    chk("bb.idle", 32'(bif.busy), 32'h0);

    // Not-taken saturation: count starts at 1
    bif.br_valid = 1'b1;
    bif.cmp_s    = 32'h0;
    repeat (65533) tick();
    chk("sat.fffe", 32'(bif.nottaken_cnt), 32'h0000_FFFE);
    repeat (4) tick();
    bif.br_valid = 1'b0;
    chk("sat.ffff", 32'(bif.nottaken_cnt), 32'h0000_FFFF);
    chk("sat.tc",   32'(bif.taken_cnt),    32'h4);

    // Reset mid-FLUSH with taken branch and stall present
    bif.br_valid  = 1'b1;
    bif.cmp_s     = 32'h1;
    bif.br_target = 32'h0000_0100;
    tick();
    chk("rf.busy", 32'(bif.busy), 32'h1);
    reset     = 1'b1;
    bif.stall = 1'b1;
    tick();
    chk_zero("rf");
    reset        = 1'b0;
    bif.stall    = 1'b0;
    bif.br_valid = 1'b0;
    tick();
    chk("rf.idle", 32'(bif.busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, SHALL set the number of cycles (1..15) that flush outputs stay high after a taken branch.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  pipeline stall from hazard unit; freezes this block's state.
REQ-005 br_valid  input  1  EX stage holds a conditional branch this cycle.
REQ-006 cmp_s  input  32  compare-unit result; bit 0 = condition true; bits 31:1 ignored.
REQ-007 br_target  input  32  branch target address computed in EX.
REQ-008 redirect_valid  output  1  one-cycle pulse: fetch SHALL load redirect_pc.
REQ-009 redirect_pc  output  32  registered branch target.
REQ-010 flush_if_id  output  1  squash IF/ID register contents.
REQ-011 flush_id_ex  output  1  squash ID/EX register contents.
REQ-012 busy  output  1  high while in FLUSH state.
REQ-013 addr_err  output  1  one-cycle pulse: taken branch to a misaligned target.
REQ-014 taken_cnt  output  16  saturating count of accepted taken branches.
REQ-015 nottaken_cnt  output  16  saturating count of accepted not-taken branches.

Function
REQ-016 FSM SHALL have two states, IDLE and FLUSH, plus a 4-bit down-counter flush_left.
REQ-017 A branch is accepted in a cycle iff state==IDLE, br_valid==1 and stall==0.
REQ-018 Accepted with cmp_s[0]==0: nottaken_cnt increments (saturating at 0xFFFF); state, redirect and flush outputs unchanged.
REQ-019 Accepted with cmp_s[0]==1 and br_target[1:0]==0: on that edge redirect_pc<=br_target, redirect_valid<=1, state<=FLUSH, flush_left<=FLUSH_CYCLES-1, taken_cnt increments (saturating).
REQ-020 Accepted with cmp_s[0]==1 and br_target[1:0]!=0: addr_err pulses 1 for the next cycle only; no redirect, no FLUSH, taken_cnt unchanged, redirect_pc holds previous value.
REQ-021 Latency: redirect_valid, flush_if_id, flush_id_ex and busy SHALL all rise in the cycle immediately after the accepting edge.
REQ-022 redirect_valid SHALL be high exactly one cycle per taken branch, regardless of stall.
REQ-023 flush_if_id and flush_id_ex SHALL equal (state==FLUSH); busy SHALL equal (state==FLUSH).
REQ-024 In FLUSH with stall==0: if flush_left==0, state<=IDLE, else flush_left decrements; with stall==1, state and flush_left hold.
REQ-025 With no stall, flush outputs SHALL therefore be high for exactly FLUSH_CYCLES consecutive cycles.
REQ-026 br_valid during FLUSH SHALL be ignored: no counting, no redirect, no addr_err (the instruction is being squashed).
REQ-027 br_valid with stall==1 in IDLE SHALL be ignored; the held instruction is accepted on the first unstalled cycle.
REQ-028 Counters SHALL hold at 0xFFFF once saturated and never wrap.
REQ-029 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-030 With reset high at a rising edge: state=IDLE, flush_left=0, redirect_valid=0, redirect_pc=0x00000000, flush_if_id=0, flush_id_ex=0, busy=0, addr_err=0, taken_cnt=0, nottaken_cnt=0.
REQ-031 Reset SHALL override every other input, including a taken branch or stall in the same cycle, and SHALL abort a FLUSH in progress.

Verification
REQ-032 Taken: br_valid=1, cmp_s=0x1, br_target=0x00400020, stall=0 -> next cycle redirect_valid=1, redirect_pc=0x00400020; flush/busy high 2 cycles; taken_cnt=1.
REQ-033 Not taken: br_valid=1, cmp_s=0xFFFFFFFE -> no redirect, no flush, nottaken_cnt=1.
REQ-034 Stall in FLUSH: taken branch, then stall=1 for 3 cycles starting in the first FLUSH cycle -> redirect_valid high 1 cycle only; flush high 5 cycles total.
REQ-035 Misaligned: br_valid=1, cmp_s=0x1, br_target=0x00400022 -> addr_err high 1 cycle, redirect_valid=0, taken_cnt unchanged.
REQ-036 Back-to-back: taken branch, then br_valid=1, cmp_s=0x1 on the next 2 cycles -> single redirect, taken_cnt=1; br_valid on the first IDLE cycle is accepted.
REQ-037 Saturation/reset: 65537 not-taken branches -> nottaken_cnt=0xFFFF; reset asserted mid-FLUSH -> all outputs 0 next cycle.
